// File: rtl/uart_line_buffer_ctrl.sv
// Line buffer between the uart_rx and uart_tx FIFO macros: pops, optionally echoes and stores rx
// characters, then replays the buffered line on start or, with AUTO_SEND set, on a stored terminator.
module uart_line_buffer_ctrl #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    DEPTH      = 16,
  parameter int                    ADDR_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] TERMINATOR = 8'h0D,
  parameter bit                    AUTO_SEND  = 1'b0,
  parameter bit                    ECHO       = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_data_present,
  output logic                  read_from_uart,
  output logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_full,
  output logic                  write_to_uart,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  busy,
  output logic                  overflow
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, RX_GAP, SEND, SEND_GAP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  line_ready_q;
  logic                  overflow_q;
  logic                  busy_q;
  logic                  rd_q;
  logic                  wr_q;
  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] ram_q [DEPTH];

  logic replay_go;
  logic rx_go;
  logic buf_full;
  logic store_en;

  assign buf_full  = (count_q == FULL_CNT);
  assign replay_go = (start && (count_q != '0)) || (AUTO_SEND && line_ready_q);
  assign rx_go     = rx_data_present && (!ECHO || !tx_full);
  assign store_en  = !reset && (state_q == IDLE) && !replay_go && rx_go && !buf_full;

  always_ff @(posedge clock) begin
    if (store_en) begin
      ram_q[wr_ptr_q] <= rx_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      line_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      tx_q         <= '0;
    end else begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (replay_go) begin
            state_q  <= SEND;
            busy_q   <= 1'b1;
            rd_ptr_q <= '0;
          end else if (rx_go) begin
            rd_q <= 1'b1;
            if (!buf_full) begin
              wr_ptr_q <= wr_ptr_q + 1'b1;
              count_q  <= count_q + 1'b1;
              if (rx_data == TERMINATOR) line_ready_q <= 1'b1;
            end else begin
              overflow_q <= 1'b1;
            end
            if (ECHO) begin
              wr_q <= 1'b1;
              tx_q <= rx_data;
            end
            state_q <= RX_GAP;
          end
        end
        RX_GAP: state_q <= IDLE;
        SEND: begin
          if (!tx_full) begin
            tx_q     <= ram_q[rd_ptr_q];
            wr_q     <= 1'b1;
            rd_ptr_q <= rd_ptr_q + 1'b1;
            state_q  <= SEND_GAP;
          end
        end
        SEND_GAP: begin
          // A full buffer wraps rd_ptr to 0, which matches the low bits of count == DEPTH.
          if (rd_ptr_q == count_q[ADDR_WIDTH-1:0]) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            line_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= IDLE;
          end else begin
            state_q <= SEND;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign read_from_uart = rd_q;
  assign write_to_uart  = wr_q;
  assign tx_data        = tx_q;
  assign count          = count_q;
  assign busy           = busy_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_uart_line_buffer_ctrl.sv
// Bench for uart_line_buffer_ctrl: dut_a is start-driven (AUTO_SEND=0), dut_b replays on terminator.
module tb_uart_line_buffer_ctrl;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          a_rst, a_start, a_rxp, a_full, a_rd, a_wr, a_busy, a_ovf;
  logic [DW-1:0] a_rxd, a_tx;
  logic [AW:0]   a_cnt;
  logic          b_rst, b_start, b_rxp, b_full, b_rd, b_wr, b_busy, b_ovf;
  logic [DW-1:0] b_rxd, b_tx;
  logic [AW:0]   b_cnt;

  uart_line_buffer_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TERMINATOR(8'h0D),
                          .AUTO_SEND(1'b0), .ECHO(1'b1)) dut_a (
    .clock(clk), .reset(a_rst), .start(a_start), .rx_data(a_rxd), .rx_data_present(a_rxp),
    .read_from_uart(a_rd), .tx_data(a_tx), .tx_full(a_full), .write_to_uart(a_wr),
    .count(a_cnt), .busy(a_busy), .overflow(a_ovf));

  uart_line_buffer_ctrl #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TERMINATOR(8'h0D),
                          .AUTO_SEND(1'b1), .ECHO(1'b1)) dut_b (
    .clock(clk), .reset(b_rst), .start(b_start), .rx_data(b_rxd), .rx_data_present(b_rxp),
    .read_from_uart(b_rd), .tx_data(b_tx), .tx_full(b_full), .write_to_uart(b_wr),
    .count(b_cnt), .busy(b_busy), .overflow(b_ovf));

  int n_assert = 0;
  int n_fail   = 0;

  // rx FIFO contents, observed tx stream, expected tx stream and modelled line buffer per DUT
  logic [7:0] a_rxq[$], a_obs[$], a_exp[$], a_buf[$];
  logic [7:0] b_rxq[$], b_obs[$], b_exp[$], b_buf[$];
  bit  a_ovf_m = 1'b0;
  int  a_reads = 0, a_reads_exp = 0, b_reads = 0, b_reads_exp = 0;
  logic a_rd_p = 1'b0, a_wr_p = 1'b0, b_rd_p = 1'b0, b_wr_p = 1'b0;
  bit  b_rand_full = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    a_rxp = (a_rxq.size() > 0);
    a_rxd = a_rxp ? a_rxq[0] : '0;
    b_rxp = (b_rxq.size() > 0);
    b_rxd = b_rxp ? b_rxq[0] : '0;
    if (b_rand_full) b_full = ($urandom_range(0, 3) == 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (a_rd) begin chk("a_rd_single_pulse", a_rd_p, 1'b0); a_reads++; if (a_rxq.size() > 0) void'(a_rxq.pop_front()); end
    if (a_wr) begin chk("a_wr_single_pulse", a_wr_p, 1'b0); a_obs.push_back(a_tx); end
    if (b_rd) begin chk("b_rd_single_pulse", b_rd_p, 1'b0); b_reads++; if (b_rxq.size() > 0) void'(b_rxq.pop_front()); end
    if (b_wr) begin chk("b_wr_single_pulse", b_wr_p, 1'b0); b_obs.push_back(b_tx); end
    a_rd_p = a_rd; a_wr_p = a_wr; b_rd_p = b_rd; b_wr_p = b_wr;
    drive();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic feed_a(input logic [7:0] c);
    a_rxq.push_back(c);
    a_reads_exp++;
    a_exp.push_back(c);
    if (a_buf.size() < DEPTH) a_buf.push_back(c);
    else a_ovf_m = 1'b1;
    drive();
  endtask

  task automatic feed_b(input logic [7:0] c);
    b_rxq.push_back(c);
    b_reads_exp++;
    b_exp.push_back(c);
    if (b_buf.size() < DEPTH) begin
      b_buf.push_back(c);
      if (c == 8'h0D) begin
        foreach (b_buf[i]) b_exp.push_back(b_buf[i]);
        b_buf.delete();
      end
    end
    drive();
  endtask

  task automatic replay_model_a();
    if (a_buf.size() > 0) begin
      foreach (a_buf[i]) a_exp.push_back(a_buf[i]);
      a_buf.delete();
      a_ovf_m = 1'b0;
    end
  endtask

  task automatic pulse_start_a();
    a_start = 1'b1;
    tick();
    a_start = 1'b0;
  endtask

  task automatic cmp_a(input string tag);
    chk({tag, "_len"}, a_obs.size(), a_exp.size());
    for (int i = 0; i < a_exp.size() && i < a_obs.size(); i++) chk({tag, "_dat"}, a_obs[i], a_exp[i]);
    chk({tag, "_reads"}, a_reads, a_reads_exp);
    chk({tag, "_count"}, a_cnt, a_buf.size());
    chk({tag, "_ovf"}, a_ovf, a_ovf_m);
    a_obs.delete();
    a_exp.delete();
  endtask

  task automatic cmp_b(input string tag);
    chk({tag, "_len"}, b_obs.size(), b_exp.size());
    for (int i = 0; i < b_exp.size() && i < b_obs.size(); i++) chk({tag, "_dat"}, b_obs[i], b_exp[i]);
    chk({tag, "_reads"}, b_reads, b_reads_exp);
    chk({tag, "_count"}, b_cnt, b_buf.size());
    b_obs.delete();
    b_exp.delete();
  endtask

  initial begin
    logic [7:0] c;
    int n, k, len;
    a_rst = 1'b1; a_start = 1'b0; a_full = 1'b0;
    b_rst = 1'b1; b_start = 1'b0; b_full = 1'b0;
    drive();

    // reset state
    tick();
    chk("rst_a_rd", a_rd, 1'b0);   chk("rst_a_wr", a_wr, 1'b0);   chk("rst_a_tx", a_tx, 8'h00);
    chk("rst_a_cnt", a_cnt, 5'd0); chk("rst_a_busy", a_busy, 1'b0); chk("rst_a_ovf", a_ovf, 1'b0);
    chk("rst_b_rd", b_rd, 1'b0);   chk("rst_b_wr", b_wr, 1'b0);   chk("rst_b_tx", b_tx, 8'h00);
    chk("rst_b_cnt", b_cnt, 5'd0); chk("rst_b_busy", b_busy, 1'b0); chk("rst_b_ovf", b_ovf, 1'b0);
    a_rst = 1'b0; b_rst = 1'b0;

    // echo and buffer two characters
    feed_a(8'h41); feed_a(8'h42);
    run(8);
    chk("ab_busy", a_busy, 1'b0);
    cmp_a("echo_ab");

    // replay on start
    replay_model_a();
    pulse_start_a();
    chk("replay_busy_on", a_busy, 1'b1);
    run(12);
    chk("replay_busy_off", a_busy, 1'b0);
    cmp_a("replay_ab");

    // start with an empty buffer is ignored
    pulse_start_a();
    chk("empty_start_busy", a_busy, 1'b0);
    run(4);
    cmp_a("empty_start");

    // echo blocked by a full tx FIFO: nothing is read
    a_full = 1'b1;
    n = a_reads;
    feed_a(8'($urandom_range(0, 255)));
    run(6);
    chk("full_no_read", a_reads, n);
    a_full = 1'b0;
    run(6);
    cmp_a("full_release");
    replay_model_a();
    pulse_start_a();
    run(8);
    cmp_a("full_release_replay");

    // AUTO_SEND line
    feed_b(8'h68); feed_b(8'h69); feed_b(8'h0D);
    run(24);
    chk("auto_busy", b_busy, 1'b0);
    cmp_b("auto_hi");

    // overflow: 18 characters into a 16-entry buffer
    for (int i = 0; i < 18; i++) feed_a(8'($urandom_range(0, 255)));
    run(18 * 2 + 10);
    chk("ovf_count16", a_cnt, 5'd16);
    chk("ovf_flag", a_ovf, 1'b1);
    cmp_a("ovf_fill");
    replay_model_a();
    pulse_start_a();
    run(40);
    chk("ovf_cleared", a_ovf, 1'b0);
    cmp_a("ovf_replay");

    // tx_full held during replay, with start pulses that must be ignored
    for (int i = 0; i < 5; i++) feed_a(8'($urandom_range(0, 255)));
    run(16);
    cmp_a("hold_fill");
    replay_model_a();
    pulse_start_a();
    run(3);
    a_full = 1'b1;
    n = a_obs.size();
    a_start = 1'b1; tick(); a_start = 1'b0;
    run(9);
    chk("hold_no_write", a_obs.size(), n);
    chk("hold_busy", a_busy, 1'b1);
    a_full = 1'b0;
    run(3);
    a_start = 1'b1; tick(); a_start = 1'b0;
    run(20);
    cmp_a("hold_replay");

    // start and a receivable character in the same cycle: replay first
    feed_a(8'h41); feed_a(8'h42);
    run(8);
    cmp_a("prio_fill");
    replay_model_a();
    feed_a(8'h43);
    pulse_start_a();
    run(20);
    cmp_a("prio_order");
    replay_model_a();
    pulse_start_a();
    run(6);
    cmp_a("prio_drain");

    // reset in the middle of a five-character replay
    for (int i = 0; i < 5; i++) feed_a(8'($urandom_range(0, 255)));
    run(16);
    cmp_a("mid_fill");
    pulse_start_a();
    k = 0;
    while (a_obs.size() < 2 && k < 40) begin tick(); k++; end
    chk("mid_two_writes_seen", a_obs.size() >= 2, 1'b1);
    a_exp.push_back(a_buf[0]); a_exp.push_back(a_buf[1]);
    a_buf.delete(); a_ovf_m = 1'b0;
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    chk("mid_rst_wr", a_wr, 1'b0);
    chk("mid_rst_busy", a_busy, 1'b0);
    chk("mid_rst_cnt", a_cnt, 5'd0);
    run(20);
    chk("mid_rst_busy_after", a_busy, 1'b0);
    cmp_a("mid_rst");
    feed_a(8'h5A);
    run(6);
    cmp_a("after_rst_z");

    // random lines with random tx backpressure on the AUTO_SEND instance
    for (int l = 0; l < 4; l++) begin
      len = $urandom_range(1, 10);
      for (int i = 0; i < len - 1; i++) begin
        c = 8'($urandom_range(0, 255));
        if (c == 8'h0D) c = 8'h0E;
        feed_b(c);
      end
      feed_b(8'h0D);
    end
    b_rand_full = 1'b1;
    run(600);
    b_rand_full = 1'b0;
    b_full = 1'b0;
    run(10);
    chk("rand_busy", b_busy, 1'b0);
    chk("rand_ovf", b_ovf, 1'b0);
    cmp_b("rand_lines");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
